tx_burst_ctrl: RTL and testbench

Burst sequencer for the TX chain: drives the chain's `en` input so that exactly `burst_len` symbols are emitted, then holds the chain idle for a fixed pipeline-drain period and a programmable inter-burst gap. It sits between the system control logic (start/abort/config) and the TX chain (bit generator -> QAM-16 mapper -> upsampler -> RRC filter). It also provides a sample gate that marks the RRC output samples belonging to the current burst.

---
 rtl/tx_burst_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tx_burst_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_ctrl.sv
// Burst sequencer for the TX chain: gates the chain enable for exactly burst_len
// symbols, then holds it low for a pipeline drain and an optional inter-burst gap.
module tx_burst_ctrl #(
  parameter int LEN_W        = 16,
  parameter int GAP_W        = 16,
  parameter int DRAIN_CYCLES = 43
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             sym_tick,
  input  logic             tx_valid,
  output logic             tx_en,
  output logic             sample_gate,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [LEN_W-1:0] sym_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // One down-counter serves both DRAIN and GAP, so it must fit either load value.
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int CNT_W = (GAP_W > DRN_W) ? GAP_W : DRN_W;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_en_q, tx_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             cfg_err_q, cfg_err_d;
  logic             launch;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    gap_d     = gap_q;
    sym_cnt_d = sym_cnt_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfg_err_d = 1'b0;
    launch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) launch = 1'b1;
      end
      S_RUN: begin
        if (sym_tick) begin
          if (sym_cnt_q == len_q - LEN_W'(1)) begin
            state_d   = S_DRAIN;
            cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
            sym_cnt_d = len_q;
          end else if (sym_cnt_q < len_q) begin
            sym_cnt_d = sym_cnt_q + LEN_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (continuous && gap_q != '0) begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(gap_q - GAP_W'(1));
          end else if (continuous) begin
            launch = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == '0) begin
          if (continuous) launch = 1'b1;
          else            state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // A refused launch always lands in IDLE, whichever state asked for it.
    if (launch) begin
      if (burst_len != '0) begin
        state_d   = S_RUN;
        len_d     = burst_len;
        gap_d     = gap_len;
        sym_cnt_d = '0;
      end else begin
        state_d   = S_IDLE;
        cfg_err_d = 1'b1;
      end
    end

    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      len_d     = len_q;
      gap_d     = gap_q;
      sym_cnt_d = sym_cnt_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
      aborted_d = 1'b1;
    end

    tx_en_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      gap_q     <= '0;
      sym_cnt_q <= '0;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      sym_cnt_q <= sym_cnt_d;
      cnt_q     <= cnt_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tx_en       = tx_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign cfg_err     = cfg_err_q;
  assign sym_cnt     = sym_cnt_q;
  assign sample_gate = tx_valid && (state_q == S_RUN || state_q == S_DRAIN);

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Scoreboard bench for tx_burst_ctrl: stimulus queues expected pulse/rise events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_tx_burst_ctrl;
  localparam int LEN_W = 16;
  localparam int GAP_W = 16;
  localparam int DRAIN = 43;

  localparam int EV_RISE  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;
  localparam int EV_CFG   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             sym_tick = 1'b0, tx_valid = 1'b0;
  logic             tx_en, sample_gate, busy, done, aborted, cfg_err;
  logic [LEN_W-1:0] sym_cnt;

  tx_burst_ctrl #(.LEN_W(LEN_W), .GAP_W(GAP_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .burst_len(burst_len), .gap_len(gap_len), .sym_tick(sym_tick), .tx_valid(tx_valid),
    .tx_en(tx_en), .sample_gate(sample_gate), .busy(busy), .done(done),
    .aborted(aborted), .cfg_err(cfg_err), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int kind;
    int at;
    int sc;
    int busy;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input int sc, input int b);
    ev_t e;
    e.kind = kind; e.at = at; e.sc = sc; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.at);
      if (e.sc >= 0) chk("ev_sym_cnt", int'(sym_cnt), e.sc);
      chk("ev_busy", int'(busy), e.busy);
    end
  endtask

  // Monitor: done before rise so same-cycle zero-gap relaunch stays ordered.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done)             got(EV_DONE);
      if (aborted)          got(EV_ABORT);
      if (cfg_err)          got(EV_CFG);
      if (tx_en && !prev_en) got(EV_RISE);
    end
    prev_en = tx_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    int g = 0;
    while (cyc < t && g < 5000) begin
      step();
      g++;
    end
    if (cyc < t) chk("wait_timeout", cyc, t);
  endtask

  task automatic launch(input int len, input int gap, input bit cont);
    burst_len  = LEN_W'(len);
    gap_len    = GAP_W'(gap);
    continuous = cont;
    start      = 1'b1;
    push(EV_RISE, cyc + 1, 0, 1);
    step();
    start = 1'b0;
  endtask

  // Issues n ticks one cycle apart; m is the edge that sampled the last one.
  task automatic ticks(input int n, output int m);
    m = 0;
    for (int i = 0; i < n; i++) begin
      chk("run_tx_en", int'(tx_en), 1);
      sym_tick = 1'b1;
      step();
      m = cyc;
      sym_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int m;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_sym_cnt", int'(sym_cnt), 0);
    chk("idle_gate", int'(sample_gate), 0);
    tx_valid = 1'b0;
    step();

    // Single burst of 8, then ignored tick/start during DRAIN.
    launch(8, 0, 0);
    ticks(8, m);
    push(EV_DONE, m + DRAIN, 8, 0);
    chk("drain_tx_en", int'(tx_en), 0);
    chk("drain_busy", int'(busy), 1);
    chk("drain_sym_cnt", int'(sym_cnt), 8);
    tx_valid = 1'b1;
    #1 chk("drain_gate", int'(sample_gate), 1);
    tx_valid = 1'b0;
    sym_tick = 1'b1;
    step();
    sym_tick = 1'b0;
    chk("drain_tick_ignored", int'(sym_cnt), 8);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(m + DRAIN + 3);
    chk("post_busy", int'(busy), 0);
    chk("post_tx_en", int'(tx_en), 0);
    chk("post_sym_cnt", int'(sym_cnt), 8);

    // Zero length is refused.
    burst_len = '0;
    start = 1'b1;
    push(EV_CFG, cyc + 1, -1, 0);
    step();
    start = 1'b0;
    step();
    chk("zero_busy", int'(busy), 0);
    chk("zero_tx_en", int'(tx_en), 0);

    // Continuous bursts of 4 with gap 20; start during GAP ignored.
    launch(4, 20, 1);
    ticks(4, m);
    push(EV_DONE, m + DRAIN, 4, 1);
    push(EV_RISE, m + DRAIN + 20, 0, 1);
    wait_until(m + DRAIN + 8);
    chk("gap_tx_en", int'(tx_en), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(m + DRAIN + 20);
    ticks(4, m);
    push(EV_DONE, m + DRAIN, 4, 1);
    push(EV_RISE, m + DRAIN + 20, 0, 1);
    wait_until(m + DRAIN + 20);
    ticks(2, m);
    continuous = 1'b0;
    ticks(2, m);
    push(EV_DONE, m + DRAIN, 4, 0);
    wait_until(m + DRAIN + 25);
    chk("cont_end_tx_en", int'(tx_en), 0);
    chk("cont_end_busy", int'(busy), 0);

    // Abort after 3 of 8 ticks.
    launch(8, 0, 0);
    ticks(3, m);
    abort = 1'b1;
    push(EV_ABORT, cyc + 1, 3, 0);
    step();
    abort = 1'b0;
    chk("abort_tx_en", int'(tx_en), 0);
    chk("abort_sym_cnt", int'(sym_cnt), 3);
    repeat (50) step();

    // Abort together with start while busy: no relaunch.
    launch(8, 0, 0);
    ticks(2, m);
    abort = 1'b1;
    start = 1'b1;
    push(EV_ABORT, cyc + 1, 2, 0);
    step();
    abort = 1'b0;
    start = 1'b0;
    repeat (5) step();
    chk("abort_start_busy", int'(busy), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("idle_abort_busy", int'(busy), 0);

    // Asynchronous reset mid-DRAIN, then a normal burst.
    launch(4, 0, 0);
    ticks(4, m);
    wait_until(m + 10);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_en", int'(tx_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sym_cnt", int'(sym_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    launch(2, 0, 0);
    ticks(2, m);
    push(EV_DONE, m + DRAIN, 2, 0);
    wait_until(m + DRAIN + 3);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
